// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: fills instruction memory and holds the CPU in reset.
// Define IMEM_LOADER_CHECKSUM_EN to add a trailing XOR checksum byte.
module imem_boot_loader #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst_n,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_HDR,
        S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0]    DEPTH_B  = 8'(DEPTH);
    localparam logic [ADDR_W:0] WORD_ONE = 1;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     n_q, n_d;
    logic [ADDR_W:0]     words_q, words_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic [31:0]         asm_q, asm_d;
    logic                ready_q, ready_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                cpu_q, cpu_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          xor_q, xor_d;
`endif

    logic accept;
    assign accept = in_valid && ready_q;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        words_d = words_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d   = xor_q;
`endif
        unique case (state_q)
            S_HDR: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                xor_d = 8'h00;
`endif
                if (accept) begin
                    if (in_data == 8'h00 || in_data > DEPTH_B) begin
                        state_d = S_ERR;
                    end else begin
                        n_d     = in_data[ADDR_W:0];
                        bcnt_d  = 2'd0;
                        words_d = '0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    asm_d  = {asm_q[23:0], in_data};
                    bcnt_d = bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d  = xor_q ^ in_data;
`endif
                    if (bcnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = words_q[ADDR_W-1:0];
                        wdata_d = {asm_q[23:0], in_data};
                        words_d = words_q + WORD_ONE;
                        if (words_q + WORD_ONE == n_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_d = S_CHK;
`else
                            state_d = S_DONE;
`endif
                        end
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept) begin
                    state_d = (in_data == xor_q) ? S_DONE : S_ERR;
                end
            end
`endif
            S_DONE, S_ERR: begin
                if (restart) begin
                    state_d = S_HDR;
                    n_d     = '0;
                    words_d = '0;
                    bcnt_d  = 2'd0;
                end
            end
            default: state_d = S_HDR;
        endcase
        ready_d = (state_d == S_HDR) || (state_d == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                  || (state_d == S_CHK)
`endif
                  ;
        // One-cycle lag lets the final write land before the CPU runs
        cpu_d = (state_q == S_DONE) && (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_HDR;
            n_q     <= '0;
            words_q <= '0;
            bcnt_q  <= 2'd0;
            asm_q   <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cpu_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q   <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            words_q <= words_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cpu_q   <= cpu_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

    assign in_ready     = ready_q;
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_rst_n    = cpu_q;
    assign load_done    = (state_q == S_DONE);
    assign load_err     = (state_q == S_ERR);
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: stimulus queues expected writes,
// a negedge monitor pops and compares them against imem write pulses.
module tb_imem_boot_loader;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        restart;
    logic        imem_we;
    logic [4:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst_n;
    logic        load_done;
    logic        load_err;
    logic [5:0]  words_loaded;

    imem_boot_loader #(.ADDR_W(5), .DEPTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .restart      (restart),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_rst_n    (cpu_rst_n),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] prog[$];
    int          n_chk  = 0;
    int          n_fail = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h expected none",
                         imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("imem_addr", 32'(imem_addr), 32'(e.addr));
                check("imem_wdata", imem_wdata, e.data);
                check("words_at_write", 32'(words_loaded), 32'(e.addr) + 1);
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit gapped);
        int t;
        t = 0;
        if (gapped) repeat ($urandom_range(0, 3)) @(negedge clk);
        @(negedge clk);
        while (in_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (in_ready !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready %b expected 1", in_ready);
        end else begin
            in_valid = 1'b1;
            in_data  = b;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_data  = 8'hxx;
        end
    endtask

    task automatic push_ignored(input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_load(input bit gapped, input bit bad_ck);
        logic [7:0] ck;
        logic [7:0] b;
        ck = 8'h00;
        send(8'(prog.size()), gapped);
        foreach (prog[i]) begin
            wr_t e;
            e.addr = 5'(i);
            e.data = prog[i];
            exp_q.push_back(e);
            for (int j = 0; j < 4; j++) begin
                b  = prog[i][31-8*j -: 8];
                ck = ck ^ b;
                send(b, gapped);
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(bad_ck ? (ck ^ 8'h01) : ck, gapped);
`else
        if (bad_ck) ck = ~ck;
`endif
    endtask

    task automatic check_done(input int n);
        @(negedge clk);
        check("load_done", 32'(load_done), 1);
        check("load_err", 32'(load_err), 0);
        check("cpu_rst_n_lag", 32'(cpu_rst_n), 0);
        check("in_ready_done", 32'(in_ready), 0);
        check("words_loaded", 32'(words_loaded), 32'(n));
        @(negedge clk);
        check("cpu_rst_n_up", 32'(cpu_rst_n), 1);
    endtask

    task automatic check_err();
        @(negedge clk);
        check("load_err", 32'(load_err), 1);
        check("load_done_err", 32'(load_done), 0);
        check("cpu_rst_n_err", 32'(cpu_rst_n), 0);
        check("in_ready_err", 32'(in_ready), 0);
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        check("rst_cpu_rst_n", 32'(cpu_rst_n), 0);
        check("rst_load_done", 32'(load_done), 0);
        check("rst_load_err", 32'(load_err), 0);
        check("rst_words", 32'(words_loaded), 0);
        check("rst_in_ready", 32'(in_ready), 1);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        restart  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 0);
        check("reset_we", 32'(imem_we), 0);
        check("reset_addr", 32'(imem_addr), 0);
        check("reset_wdata", imem_wdata, 0);
        check("reset_cpu_rst_n", 32'(cpu_rst_n), 0);
        check("reset_done", 32'(load_done), 0);
        check("reset_err", 32'(load_err), 0);
        check("reset_words", 32'(words_loaded), 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(in_ready), 1);

        prog = '{32'h20080005};
        run_load(1'b0, 1'b0);
        check_done(1);

        do_restart();
        prog.delete();
        for (int k = 0; k < 32; k++) prog.push_back(32'(k));
        run_load(1'b0, 1'b0);
        check_done(32);
        repeat (3) push_ignored(8'h5A);
        @(negedge clk);
        check("words_after_extra", 32'(words_loaded), 32);
        check("in_ready_after_extra", 32'(in_ready), 0);

        do_restart();
        send(8'h00, 1'b0);
        check_err();
        do_restart();
        send(8'h21, 1'b0);
        check_err();

        do_restart();
        prog = '{32'h11223344, 32'hA5A5A5A5, 32'h00FF00FF};
        run_load(1'b1, 1'b0);
        check_done(3);

`ifdef IMEM_LOADER_CHECKSUM_EN
        do_restart();
        prog = '{32'hDEADBEEF};
        run_load(1'b0, 1'b0);
        check_done(1);
        do_restart();
        run_load(1'b0, 1'b1);
        check_err();
        check("words_bad_ck", 32'(words_loaded), 1);
`endif

        do_restart();
        begin
            wr_t e;
            e.addr = 5'd0;
            e.data = 32'h01020304;
            exp_q.push_back(e);
        end
        send(8'h02, 1'b0);
        send(8'h01, 1'b0);
        restart = 1'b1;
        send(8'h02, 1'b0);
        restart = 1'b0;
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        send(8'h09, 1'b0);
        check("restart_ignored_words", 32'(words_loaded), 1);
        #3;
        rst = 1'b1;
        #1;
        check("async_in_ready", 32'(in_ready), 0);
        check("async_we", 32'(imem_we), 0);
        check("async_addr", 32'(imem_addr), 0);
        check("async_wdata", imem_wdata, 0);
        check("async_words", 32'(words_loaded), 0);
        check("async_cpu_rst_n", 32'(cpu_rst_n), 0);
        check("async_done", 32'(load_done), 0);
        @(negedge clk);
        rst = 1'b0;
        prog = '{32'hCAFEF00D};
        run_load(1'b0, 1'b0);
        check_done(1);

        repeat (3) @(negedge clk);
        check("pending_writes", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
